// File: rtl/mnist_pkg.sv
// mnist_pkg: shared widths and datapath types for the MNIST classifier.
package mnist_pkg;
  localparam int PIX_W = 8;
  localparam int WT_W = 8;
  localparam int ACC_W = 32;
  localparam int HL_INPUTS = 784;
  typedef logic [PIX_W-1:0] pix_t;
  typedef logic signed [WT_W-1:0] wt_t;
  typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/pe_mul_u8s8.sv
// pe_mul_u8s8: unsigned-by-signed multiplier producing a full-width signed product.
module pe_mul_u8s8 #(
  parameter int IN_W = 8,
  parameter int WT_W = 8
) (
  input  logic [IN_W-1:0]    ifmap,
  input  logic [WT_W-1:0]    weight,
  output logic [IN_W+WT_W:0] prod
);
  logic [IN_W+WT_W:0] a, b;
  // both operands widened to the product width, so the low bits of the product are exact
  assign a = {{(WT_W+1){1'b0}}, ifmap};
  assign b = {{(IN_W+1){weight[WT_W-1]}}, weight};
  assign prod = a * b;
endmodule

// File: rtl/pe_hl_mac.sv
// pe_hl_mac: hidden-layer MAC with a combinational psum path and an internal accumulator.
module pe_hl_mac import mnist_pkg::*; #(
  parameter int IN_W = PIX_W,
  parameter int WT_W = mnist_pkg::WT_W,
  parameter int ACC_W = mnist_pkg::ACC_W,
  parameter int CNT_W = $clog2(HL_INPUTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  ifmap,
  input  logic [WT_W-1:0]  weight,
  input  logic [ACC_W-1:0] psum,
  output logic [ACC_W-1:0] ofmap,
  input  logic             en,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CNT_W-1:0] mac_cnt
);
  localparam int P_W = IN_W + WT_W + 1;
  logic [P_W-1:0] prod;
  logic [ACC_W-1:0] prod_x, acc, sum;
  logic ovf_now;
  pe_mul_u8s8 #(.IN_W(IN_W), .WT_W(WT_W)) u_mul (.ifmap(ifmap), .weight(weight), .prod(prod));
  assign prod_x = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  assign ofmap = psum + prod_x;
  assign sum = acc + prod_x;
  // signed overflow: like-signed operands yielding a result of the other sign
  assign ovf_now = (acc[ACC_W-1] == prod_x[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign acc_out = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      mac_cnt <= '0;
    end else if (clr) begin
      acc <= en ? prod_x : '0;
      mac_cnt <= en ? CNT_W'(1) : '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum;
      ovf <= ovf | ovf_now;
      mac_cnt <= (&mac_cnt) ? mac_cnt : mac_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pe_hl_mac.sv
// tb_pe_hl_mac: scoreboard bench for pe_hl_mac against an integer reference model.
module tb_pe_hl_mac;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [7:0] ifmap = '0, weight = '0;
  logic [31:0] psum = '0, ofmap, acc_out;
  logic ovf;
  logic [9:0] mac_cnt;

  always #5 clk = ~clk;

  pe_hl_mac dut (
    .clk(clk), .rst(rst), .ifmap(ifmap), .weight(weight), .psum(psum), .ofmap(ofmap),
    .en(en), .clr(clr), .acc_out(acc_out), .ovf(ovf), .mac_cnt(mac_cnt)
  );

  typedef struct {
    logic [31:0] of;
    logic [31:0] acc;
    logic        ovf;
    logic [9:0]  cnt;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit have_pend = 0;
  int checks = 0, errors = 0;
  longint m_acc = 0;
  bit m_ovf = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic with overflow judged by true range.
  task automatic step(input bit r, input bit c, input bit e, input int ifm, input int wt,
                      input logic [31:0] ps, output logic [31:0] of_exp);
    int prod;
    longint s;
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; clr = c; en = e;
    ifmap = ifm[7:0]; weight = wt[7:0]; psum = ps;
    prod = ifm * wt;
    x.of = ps + prod;
    if (r) begin
      m_acc = 0; m_ovf = 0; m_cnt = 0;
    end else if (c) begin
      m_acc = e ? prod : 0; m_cnt = e ? 1 : 0; m_ovf = 0;
    end else if (e) begin
      s = m_acc + prod;
      if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1;
      m_acc = $signed(s[31:0]);
      m_cnt = (m_cnt == 1023) ? 1023 : m_cnt + 1;
    end
    x.acc = m_acc[31:0];
    x.ovf = m_ovf;
    x.cnt = m_cnt[9:0];
    of_exp = x.of;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (have_pend) begin
      chk("acc_out", acc_out, pend.acc);
      chk("ovf", {31'b0, ovf}, {31'b0, pend.ovf});
      chk("mac_cnt", {22'b0, mac_cnt}, {22'b0, pend.cnt});
    end
    have_pend = 0;
    if (q.size() > 0) begin
      pend = q.pop_front();
      have_pend = 1;
      chk("ofmap", ofmap, pend.of);
    end
  end

  int pa[6] = '{130, 52, 25, 255, 10, 20};
  int pw[6] = '{-30, 70, 60, 50, 40, -128};

  initial begin
    logic [31:0] ps, o;
    step(1, 0, 0, 0, 0, 32'd0, o);
    ps = 32'd0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, pa[i], pw[i], ps, o);
      ps = o;
    end
    step(0, 0, 0, 255, -128, 32'd0, o);
    step(0, 0, 0, 255, 127, 32'd0, o);
    step(0, 0, 0, 0, -128, 32'd0, o);
    step(0, 0, 0, 255, 127, 32'h7FFFFFFF, o);
    step(0, 1, 1, 130, -30, 32'd5, o);
    step(0, 0, 1, 52, 70, 32'd9, o);
    step(0, 0, 0, 1, 1, 32'd0, o);
    step(0, 0, 1, 200, -100, 32'hDEAD0000, o);
    step(1, 1, 1, 77, 33, 32'h12345678, o);
    step(0, 0, 0, 3, -3, 32'd100, o);
    step(0, 1, 1, 255, 6, 32'd0, o);
    for (int i = 0; i < 66310; i++) step(0, 0, 1, 255, 127, 32'd0, o);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 255, 127, 32'd0, o);
    step(0, 0, 1, 255, -128, 32'd0, o);
    step(0, 1, 0, 9, 9, 32'd0, o);
    step(0, 0, 1, 255, -128, 32'd0, o);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)) - 128, $urandom, o);
    @(posedge clk);
    #1;
    en = 0; clr = 0; rst = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
